// File: rtl/snek_vga_pkg.sv
// snek_vga_pkg: 640x480@60 timing shared by the snek generator and the receive-side decoder
package snek_vga_pkg;
    localparam int H_VISIBLE = 640;
    localparam int H_SYNC = 96;
    localparam int H_BP = 48;
    localparam int H_TOTAL = 800;
    localparam int V_VISIBLE = 480;
    localparam int V_SYNC = 2;
    localparam int V_BP = 33;
    localparam int V_TOTAL = 525;
    localparam logic SYNC_POL = 1'b0;
    localparam int LOCK_FRAMES = 2;
    localparam int H_ACT_START = H_SYNC + H_BP;
    localparam int V_ACT_START = V_SYNC + V_BP;
    typedef enum logic [1:0] {SEARCH, ACQUIRE, LOCKED} lock_state_e;
endpackage

// File: rtl/vga_edge_detect.sv
// vga_edge_detect: registers a sync input once and pulses on its transition into the asserted level
module vga_edge_detect #(
    parameter logic POL = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic sync,
    output logic lead
);
    logic sync_r, sync_p;
    always_ff @(posedge clk) begin
        if (!rst) begin
            sync_r <= POL;
            sync_p <= POL;
        end else begin
            sync_r <= sync;
            sync_p <= sync_r;
        end
    end
    assign lead = (sync_r == POL) && (sync_p != POL);
endmodule

// File: rtl/vga_sync_decoder.sv
// vga_sync_decoder: checks an hsync/vsync/rgb stream against its timing, locks, and recovers x/y/de plus a pixel probe
module vga_sync_decoder #(
    parameter int H_VISIBLE = snek_vga_pkg::H_VISIBLE,
    parameter int H_SYNC = snek_vga_pkg::H_SYNC,
    parameter int H_BP = snek_vga_pkg::H_BP,
    parameter int H_TOTAL = snek_vga_pkg::H_TOTAL,
    parameter int V_VISIBLE = snek_vga_pkg::V_VISIBLE,
    parameter int V_SYNC = snek_vga_pkg::V_SYNC,
    parameter int V_BP = snek_vga_pkg::V_BP,
    parameter int V_TOTAL = snek_vga_pkg::V_TOTAL,
    parameter logic SYNC_POL = snek_vga_pkg::SYNC_POL,
    parameter int LOCK_FRAMES = snek_vga_pkg::LOCK_FRAMES
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       hsync,
    input  logic       vsync,
    input  logic [2:0] rgb,
    input  logic [9:0] probe_x,
    input  logic [9:0] probe_y,
    output logic [9:0] x,
    output logic [9:0] y,
    output logic       de,
    output logic [2:0] pix,
    output logic       frame_start,
    output logic       locked,
    output logic       err,
    output logic [2:0] probe_rgb,
    output logic       probe_valid
);
    import snek_vga_pkg::*;
    localparam logic [9:0] H_ACT = 10'(H_SYNC + H_BP);
    localparam logic [9:0] H_END = 10'(H_SYNC + H_BP + H_VISIBLE);
    localparam logic [9:0] H_LAST = 10'(H_TOTAL - 1);
    localparam logic [9:0] H_MAX = 10'(H_TOTAL);
    localparam logic [9:0] V_ACT = 10'(V_SYNC + V_BP);
    localparam logic [9:0] V_END = 10'(V_SYNC + V_BP + V_VISIBLE);
    localparam logic [9:0] V_LAST = 10'(V_TOTAL - 1);
    localparam logic [9:0] V_MAX = 10'(V_TOTAL);
    localparam int GW = $clog2(LOCK_FRAMES + 1);
    localparam logic [GW-1:0] G_LAST = GW'(LOCK_FRAMES - 1);

    logic h_lead, v_lead;
    logic [2:0] rgb_r, rgb_d;
    logic [9:0] hcnt, vcnt, px_s, py_s;
    logic vpend, h_chk, v_chk, fs_q, err_q;
    logic boundary, h_bad, v_bad, viol, vis, de_n, hit;
    lock_state_e state;
    logic [GW-1:0] good;

    vga_edge_detect #(.POL(SYNC_POL)) u_hsync (.clk(clk), .rst(rst), .sync(hsync), .lead(h_lead));
    vga_edge_detect #(.POL(SYNC_POL)) u_vsync (.clk(clk), .rst(rst), .sync(vsync), .lead(v_lead));

    // h_chk/v_chk stay low until the first edge after reset or a violation, so that edge is never judged
    always_comb begin
        boundary = h_lead && (vpend || v_lead);
        h_bad = h_lead ? h_chk && hcnt != H_LAST : hcnt == H_LAST;
        v_bad = boundary ? v_chk && vcnt != V_LAST : h_lead && vcnt == V_LAST;
        viol = h_bad || v_bad;
        vis = hcnt >= H_ACT && hcnt < H_END && vcnt >= V_ACT && vcnt < V_END;
        de_n = vis && state == LOCKED && !err_q;
        hit = de && x == px_s && y == py_s;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            rgb_r <= '0;
            rgb_d <= '0;
            hcnt <= '0;
            vcnt <= '0;
            vpend <= 1'b0;
            h_chk <= 1'b0;
            v_chk <= 1'b0;
            fs_q <= 1'b0;
            err_q <= 1'b0;
        end else begin
            rgb_r <= rgb;
            rgb_d <= rgb_r;
            hcnt <= h_lead ? '0 : hcnt == H_MAX ? hcnt : hcnt + 10'd1;
            vcnt <= boundary ? '0 : h_lead && vcnt != V_MAX ? vcnt + 10'd1 : vcnt;
            vpend <= !boundary && (vpend || v_lead);
            h_chk <= !viol && (h_chk || h_lead);
            v_chk <= !viol && (v_chk || boundary);
            fs_q <= boundary;
            err_q <= viol;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            x <= '0;
            y <= '0;
            de <= 1'b0;
            pix <= '0;
            frame_start <= 1'b0;
            err <= 1'b0;
        end else begin
            de <= de_n;
            x <= de_n ? hcnt - H_ACT : '0;
            y <= de_n ? vcnt - V_ACT : '0;
            pix <= de_n ? rgb_d : '0;
            frame_start <= fs_q;
            err <= err_q;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst || err_q) begin
            state <= SEARCH;
            good <= '0;
            locked <= 1'b0;
        end else if (fs_q) begin
            case (state)
                SEARCH: begin
                    state <= ACQUIRE;
                    good <= '0;
                end
                ACQUIRE: begin
                    good <= good + 1'b1;
                    state <= good == G_LAST ? LOCKED : ACQUIRE;
                    locked <= good == G_LAST;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            px_s <= '0;
            py_s <= '0;
            probe_rgb <= '0;
            probe_valid <= 1'b0;
        end else begin
            px_s <= fs_q ? probe_x : px_s;
            py_s <= fs_q ? probe_y : py_s;
            probe_rgb <= hit ? pix : probe_rgb;
            probe_valid <= hit;
        end
    end
endmodule

// File: tb/tb_vga_sync_decoder.sv
// tb_vga_sync_decoder: scoreboard bench driving a reduced-size raster through vga_sync_decoder
module tb_vga_sync_decoder;
    localparam int HS = 4, HBP = 4, HV = 16, HT = 32;
    localparam int VS = 2, VBP = 3, VV = 6, VT = 14;
    localparam int PX = 5, PY = 3, RST_H = 28;

    logic clk = 1'b0, rst = 1'b0, hsync = 1'b1, vsync = 1'b1;
    logic [2:0] rgb = '0;
    logic [9:0] probe_x = 10'(PX), probe_y = 10'(PY);
    logic [9:0] x, y;
    logic de, frame_start, locked, err, probe_valid;
    logic [2:0] pix, probe_rgb;

    typedef struct {int c; logic [9:0] x; logic [9:0] y; logic [2:0] rgb;} px_t;
    typedef struct {int c; logic v;} ev_t;
    px_t q_px[$];
    px_t q_pr[$];
    ev_t q_lock[$];
    int q_fs[$];
    int q_err[$];
    int cyc = 0, tests = 0, fails = 0;
    logic lk_prev = 1'b0;

    vga_sync_decoder #(
        .H_VISIBLE(HV), .H_SYNC(HS), .H_BP(HBP), .H_TOTAL(HT),
        .V_VISIBLE(VV), .V_SYNC(VS), .V_BP(VBP), .V_TOTAL(VT),
        .SYNC_POL(1'b0), .LOCK_FRAMES(2)
    ) dut (
        .clk(clk), .rst(rst), .hsync(hsync), .vsync(vsync), .rgb(rgb),
        .probe_x(probe_x), .probe_y(probe_y), .x(x), .y(y), .de(de), .pix(pix),
        .frame_start(frame_start), .locked(locked), .err(err),
        .probe_rgb(probe_rgb), .probe_valid(probe_valid)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic bad(input string what, input string msg);
        fails++;
        $display("FAIL %s: %s", what, msg);
    endtask

    task automatic check_zero(input string tag);
        tests++;
        if ({x, y, de, pix, frame_start, locked, err, probe_rgb, probe_valid} != '0)
            bad(tag, $sformatf("x=%0d y=%0d de=%b pix=%b fs=%b locked=%b err=%b probe_rgb=%b probe_valid=%b, want all 0",
                x, y, de, pix, frame_start, locked, err, probe_rgb, probe_valid));
    endtask

    initial forever begin
        px_t e;
        ev_t l;
        int c;
        @(posedge clk);
        #1;
        if (de || (q_px.size() != 0 && q_px[0].c <= cyc)) begin
            tests++;
            if (q_px.size() == 0) bad("pixel", $sformatf("cyc %0d de=1 x=%0d y=%0d, want de=0", cyc, x, y));
            else begin
                e = q_px.pop_front();
                if (!de || e.c != cyc || x != e.x || y != e.y || pix != e.rgb)
                    bad("pixel", $sformatf("cyc %0d de=%b x=%0d y=%0d pix=%b, want cyc %0d de=1 x=%0d y=%0d pix=%b",
                        cyc, de, x, y, pix, e.c, e.x, e.y, e.rgb));
            end
        end else begin
            tests++;
            if (x != 0 || y != 0 || pix != 0) bad("blank", $sformatf("cyc %0d x=%0d y=%0d pix=%b with de=0, want 0", cyc, x, y, pix));
        end
        if (frame_start || (q_fs.size() != 0 && q_fs[0] <= cyc)) begin
            tests++;
            c = q_fs.size() != 0 ? q_fs.pop_front() : -1;
            if (!frame_start || c != cyc) bad("frame_start", $sformatf("cyc %0d frame_start=%b, want pulse at cyc %0d", cyc, frame_start, c));
        end
        if (err || (q_err.size() != 0 && q_err[0] <= cyc)) begin
            tests++;
            c = q_err.size() != 0 ? q_err.pop_front() : -1;
            if (!err || c != cyc) bad("err", $sformatf("cyc %0d err=%b, want pulse at cyc %0d", cyc, err, c));
        end
        if (locked != lk_prev || (q_lock.size() != 0 && q_lock[0].c <= cyc)) begin
            tests++;
            if (q_lock.size() == 0) bad("locked", $sformatf("cyc %0d locked=%b, want %b", cyc, locked, lk_prev));
            else begin
                l = q_lock.pop_front();
                if (locked != l.v || l.c != cyc) bad("locked", $sformatf("cyc %0d locked=%b, want %b at cyc %0d", cyc, locked, l.v, l.c));
            end
        end
        lk_prev = locked;
        if (probe_valid || (q_pr.size() != 0 && q_pr[0].c <= cyc)) begin
            tests++;
            if (q_pr.size() == 0) bad("probe", $sformatf("cyc %0d probe_valid=1 rgb=%b, want no pulse", cyc, probe_rgb));
            else begin
                e = q_pr.pop_front();
                if (!probe_valid || e.c != cyc || probe_rgb != e.rgb)
                    bad("probe", $sformatf("cyc %0d valid=%b rgb=%b, want valid at cyc %0d rgb=%b", cyc, probe_valid, probe_rgb, e.c, e.rgb));
            end
        end
    end

    task automatic frame(input bit px_on, input bit vs_on, input int short_ln, input bit rise, input int rst_ln);
        bit on = px_on;
        for (int v = 0; v < VT; v++) begin
            int len = v == short_ln ? HT - 1 : HT;
            for (int h = 0; h < len; h++) begin
                logic [2:0] r;
                @(negedge clk);
                if (v == rst_ln && h == RST_H + 1) check_zero("midframe_reset");
                r = (h == HS + HBP + PX && v == VS + VBP + PY) ? 3'b101 : {1'b0, 2'(h + v)};
                rst = !(v == rst_ln && h == RST_H);
                hsync = h >= HS;
                vsync = !(vs_on && v < VS);
                rgb = r;
                if (!rst) begin
                    on = 1'b0;
                    q_lock.push_back('{cyc + 1, 1'b0});
                end
                if (h == 0 && v == 0 && vs_on) q_fs.push_back(cyc + 3);
                if (h == 0 && v == 0 && vs_on && rise) q_lock.push_back('{cyc + 3, 1'b1});
                if (h == 0 && ((v == 0 && !vs_on) || (short_ln >= 0 && v == short_ln + 1))) begin
                    q_err.push_back(cyc + 3);
                    q_lock.push_back('{cyc + 3, 1'b0});
                end
                if (on && h >= HS + HBP && h < HS + HBP + HV && v >= VS + VBP && v < VS + VBP + VV)
                    q_px.push_back('{cyc + 3, 10'(h - HS - HBP), 10'(v - VS - VBP), r});
                if (on && h == HS + HBP + PX && v == VS + VBP + PY)
                    q_pr.push_back('{cyc + 4, 10'(PX), 10'(PY), r});
            end
        end
    endtask

    initial begin
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check_zero("reset");
            hsync = 1'($urandom);
            vsync = 1'($urandom);
            rgb = 3'($urandom);
        end
        @(negedge clk);
        rst = 1'b1;
        hsync = 1'b1;
        vsync = 1'b1;
        rgb = '0;
        repeat (2) @(negedge clk);
        frame(0, 1, -1, 0, -1);
        frame(0, 1, -1, 0, -1);
        frame(1, 1, -1, 1, -1);
        frame(1, 1, -1, 0, -1);
        frame(1, 1, -1, 0, -1);
        frame(0, 1, 3, 0, -1);
        frame(0, 1, -1, 0, -1);
        frame(0, 1, -1, 0, -1);
        frame(1, 1, -1, 1, -1);
        frame(1, 1, -1, 0, -1);
        frame(0, 0, -1, 0, -1);
        frame(0, 1, -1, 0, -1);
        frame(0, 1, -1, 0, -1);
        frame(1, 1, -1, 1, -1);
        frame(1, 1, -1, 0, 5);
        frame(0, 1, -1, 0, -1);
        frame(0, 1, -1, 0, -1);
        frame(1, 1, -1, 1, -1);
        tests++;
        if (q_px.size() + q_pr.size() + q_lock.size() + q_fs.size() + q_err.size() != 0)
            bad("drain", $sformatf("px=%0d probe=%0d lock=%0d fs=%0d err=%0d events outstanding, want 0",
                q_px.size(), q_pr.size(), q_lock.size(), q_fs.size(), q_err.size()));
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/vga_sync_decoder.md
# vga_sync_decoder

Receive-side counterpart of the snek VGA output. It samples the hsync/vsync/rgb stream on the pixel clock, checks the timing against the 640x480@60 format, and acquires lock. Once locked it recovers pixel coordinates and a data-enable signal. A single-pixel probe captures the colour at a chosen coordinate. It sits beside `snek` in loopback builds and testbenches so a frame can be self-checked on-chip without a monitor.

## Interface
- H_VISIBLE, 640, active pixels per line
- H_SYNC, 96, hsync width in clocks
- H_BP, 48, back porch in clocks
- H_TOTAL, 800, clocks per line
- V_VISIBLE, 480, active lines
- V_SYNC, 2, vsync width in lines
- V_BP, 33, back porch in lines
- V_TOTAL, 525, lines per frame
- SYNC_POL, 0, asserted sync level (0 = active-low)
- LOCK_FRAMES, 2, consecutive good frames required for lock
- clk  in  1  pixel clock (25 MHz PLL output)
- rst  in  1  reset. One clock; reset is synchronous and active-low.
- hsync  in  1  horizontal sync from generator
- vsync  in  1  vertical sync from generator
- rgb  in  3  {red, green, blue}
- probe_x  in  10  probe column
- probe_y  in  10  probe row
- x  out  10  recovered column; 0 when de=0
- y  out  10  recovered row; 0 when de=0
- de  out  1  locked and in visible window
- pix  out  3  sampled rgb; 0 when de=0
- frame_start  out  1  one-cycle pulse at each frame boundary
- locked  out  1  lock status
- err  out  1  one-cycle pulse on any timing violation
- probe_rgb  out  3  colour captured at probe coordinate
- probe_valid  out  1  one-cycle pulse when probe_rgb updates

## Operation
- Inputs are registered once. The leading edge is the transition of the registered sync into the SYNC_POL level.
- hcnt: set to 0 on an hsync leading edge, otherwise increments.
- vsync leading edge sets `vpend`.
- vcnt: the first hsync leading edge with `vpend` set, or in the same cycle as the vsync edge, sets vcnt=0, clears `vpend` and pulses frame_start. Every other hsync leading edge increments vcnt.
- Visible window:
  - hcnt in [H_SYNC+H_BP, H_SYNC+H_BP+H_VISIBLE)
  - vcnt in [V_SYNC+V_BP, V_SYNC+V_BP+V_VISIBLE)
  - x = hcnt−(H_SYNC+H_BP); y = vcnt−(V_SYNC+V_BP).
- Violations (each pulses err):
  - hsync leading edge with previous hcnt ≠ H_TOTAL−1.
  - hcnt reaching H_TOTAL with no edge. hcnt saturates at H_TOTAL.
  - frame boundary with previous vcnt ≠ V_TOTAL−1.
  - vcnt reaching V_TOTAL with no boundary. vcnt saturates.
  - The first edge after reset or SEARCH is never a violation.
- Lock FSM:
  - SEARCH: at the next frame_start go to ACQUIRE with good=0.
  - ACQUIRE: each subsequent violation-free frame_start increments good. When good reaches LOCK_FRAMES go to LOCKED. Any violation returns to SEARCH.
  - LOCKED: any violation returns to SEARCH.
  - locked = (state==LOCKED).
- Probe:
  - probe_x/probe_y are shadowed on frame_start.
  - When de and x,y equal the shadow values, pix is copied to probe_rgb and probe_valid pulses.
  - probe_rgb holds between captures.

## Timing
- Reset (rst=0 at a clk edge): all outputs 0, hcnt=vcnt=0, vpend=0, FSM=SEARCH, probe shadows 0.
- Latency: x, y, de and pix describe the rgb on the pins 2 clk earlier. frame_start, err and locked follow the causing sync edge by 2 clk. probe_rgb and probe_valid follow 1 clk after the matching de cycle.
- A violation and a frame_start in the same cycle: the violation wins. FSM goes to SEARCH, good is not incremented, and locked falls in that cycle.
- frame_start does not re-enter ACQUIRE from the SEARCH entered in the same cycle; the next frame_start does.
- Reset asserted mid-frame: state clears on that edge. Re-lock then needs 1 + LOCK_FRAMES frame boundaries.
- Counter widths are 10 bits; all parameters must be < 1024.

## Structure
- Package `snek_vga_pkg` holds:
  - the 640x480@60 timing constants shared with the snek generator
  - the lock-state enum {SEARCH, ACQUIRE, LOCKED}
  - derived constants H_ACT_START and V_ACT_START.
- Sub-module `vga_edge_detect` (input register, leading-edge pulse, polarity parameter) is instantiated twice, for hsync and vsync.

## Test plan
- rst=0 for 4 clk during random inputs → every output 0, locked=0.
- Clean 640x480 stream from the bench generator:
  - locked rises 2 clk after the 3rd frame boundary.
  - Next frame: first de=1 shows x=0, y=0 at 144 clk after the leading edge of the hsync on line 35.
- Probe (100,50), generator drives rgb=3'b101 only at that pixel → probe_rgb=3'b101, exactly one probe_valid pulse per frame.
- While locked, one line of 799 clk → single err pulse, locked=0. Relocked after 3 further clean boundaries.
- While locked, vsync held deasserted → err when vcnt reaches 525, locked=0, no frame_start.
- While locked, rst=0 for 1 clk at line 200 → locked=0 next cycle; relock after 3 boundaries; probe_rgb reset to 0.
